// File: rtl/mem_arbiter_cache.sv
// mem_arbiter_cache: routes consumer read/write requests onto a fixed set of
// memory channels. Each channel claims one consumer at a time, forwards the
// request to memory and relays the response back until the consumer releases.
module mem_arbiter_cache #(
  parameter int ADDR_BITS         = 8,
  parameter int CONSUMER_BUS_BITS = 8,
  parameter int NUM_CONSUMERS     = 4,
  parameter int NUM_CHANNELS      = 1,
  parameter int MEMORY_BUS_BITS   = 8
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [NUM_CONSUMERS-1:0]                          consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]           consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                          consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][CONSUMER_BUS_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                          consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]           consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][CONSUMER_BUS_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                          consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                           mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]            mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                           mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][MEMORY_BUS_BITS-1:0]      mem_read_data,
  output logic [NUM_CHANNELS-1:0]                           mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]            mem_write_address,
  output logic [NUM_CHANNELS-1:0][MEMORY_BUS_BITS-1:0]      mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                           mem_write_ready
);

  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_WAIT  = 3'd1;
  localparam logic [2:0] S_WR_WAIT  = 3'd2;
  localparam logic [2:0] S_RD_RELAY = 3'd3;
  localparam logic [2:0] S_WR_RELAY = 3'd4;

  logic [NUM_CHANNELS-1:0][2:0]                 state, state_nxt;
  logic [NUM_CHANNELS-1:0][IW-1:0]              idx, idx_nxt;
  logic [NUM_CHANNELS-1:0][MEMORY_BUS_BITS-1:0] rdata, rdata_nxt;
  logic [NUM_CONSUMERS-1:0]                     taken;

  // State register: per-channel FSM state, claimed consumer and captured read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= '0;
      idx   <= '0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      rdata <= rdata_nxt;
    end
  end

  // Next-state: channels arbitrate in index order; the claim vector is updated
  // as each channel claims, so higher channels never pick an already-taken consumer.
  always_comb begin
    logic found;
    state_nxt = state;
    idx_nxt   = idx;
    rdata_nxt = rdata;
    taken     = '0;
    found     = 1'b0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++)
      if (state[ch] != S_IDLE) taken[idx[ch]] = 1'b1;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      found = 1'b0;
      case (state[ch])
        S_IDLE: begin
          // Reads are scanned first so a read beats a write from any consumer.
          for (int c = 0; c < NUM_CONSUMERS; c++)
            if (!found && consumer_read_valid[c] && !taken[c]) begin
              found         = 1'b1;
              idx_nxt[ch]   = IW'(c);
              state_nxt[ch] = S_RD_WAIT;
            end
          for (int c = 0; c < NUM_CONSUMERS; c++)
            if (!found && consumer_write_valid[c] && !taken[c]) begin
              found         = 1'b1;
              idx_nxt[ch]   = IW'(c);
              state_nxt[ch] = S_WR_WAIT;
            end
          if (found) taken[idx_nxt[ch]] = 1'b1;
        end
        S_RD_WAIT:
          if (mem_read_ready[ch]) begin
            state_nxt[ch] = S_RD_RELAY;
            rdata_nxt[ch] = mem_read_data[ch];
          end
        S_WR_WAIT:
          if (mem_write_ready[ch]) state_nxt[ch] = S_WR_RELAY;
        S_RD_RELAY:
          if (!consumer_read_valid[idx[ch]]) state_nxt[ch] = S_IDLE;
        S_WR_RELAY:
          if (!consumer_write_valid[idx[ch]]) state_nxt[ch] = S_IDLE;
        default: state_nxt[ch] = S_IDLE;
      endcase
    end
  end

  // Outputs: decoded from state so everything is 0 whenever a channel is idle
  // (including right after reset). Consumers hold address/data stable until
  // ready, so memory-side address/data are taken straight from the claimed port.
  always_comb begin
    mem_read_valid       = '0;
    mem_read_address     = '0;
    mem_write_valid      = '0;
    mem_write_address    = '0;
    mem_write_data       = '0;
    consumer_read_ready  = '0;
    consumer_read_data   = '0;
    consumer_write_ready = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      case (state[ch])
        S_RD_WAIT: begin
          mem_read_valid[ch]   = 1'b1;
          mem_read_address[ch] = consumer_read_address[idx[ch]];
        end
        S_WR_WAIT: begin
          mem_write_valid[ch]   = 1'b1;
          mem_write_address[ch] = consumer_write_address[idx[ch]];
          mem_write_data[ch]    = consumer_write_data[idx[ch]];
        end
        S_RD_RELAY: begin
          consumer_read_ready[idx[ch]] = 1'b1;
          consumer_read_data[idx[ch]]  = rdata[ch];
        end
        S_WR_RELAY: consumer_write_ready[idx[ch]] = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_cache.sv
// Bench for mem_arbiter_cache: an 8-consumer/4-channel instance plus a
// 2-fetcher/1-channel read-only instance, each behind a simple memory model.
module tb_mem_arbiter_cache;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- 8 consumers / 4 channels ----------------
  logic [7:0]       crv, crr, cwv, cwr;
  logic [7:0][7:0]  cra, crd, cwa, cwd;
  logic [3:0]       mrv, mrr, mwv, mwr;
  logic [3:0][7:0]  mra, mrd, mwa, mwd;

  mem_arbiter_cache #(.ADDR_BITS(8), .CONSUMER_BUS_BITS(8), .NUM_CONSUMERS(8),
                      .NUM_CHANNELS(4), .MEMORY_BUS_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr));

  // ---------------- 2 fetchers / 1 channel, write side unused ----------------
  logic [1:0]       s_crv, s_crr, s_cwr;
  logic [1:0][7:0]  s_cra, s_crd;
  logic [0:0]       s_mrv, s_mrr, s_mwv;
  logic [0:0][7:0]  s_mra, s_mrd, s_mwa, s_mwd;

  mem_arbiter_cache #(.ADDR_BITS(8), .CONSUMER_BUS_BITS(8), .NUM_CONSUMERS(2),
                      .NUM_CHANNELS(1), .MEMORY_BUS_BITS(8)) dut_s (
    .clk(clk), .reset(reset),
    .consumer_read_valid(s_crv), .consumer_read_address(s_cra),
    .consumer_read_ready(s_crr), .consumer_read_data(s_crd),
    .consumer_write_valid(2'b00), .consumer_write_address(16'h0000),
    .consumer_write_data(16'h0000), .consumer_write_ready(s_cwr),
    .mem_read_valid(s_mrv), .mem_read_address(s_mra),
    .mem_read_ready(s_mrr), .mem_read_data(s_mrd),
    .mem_write_valid(s_mwv), .mem_write_address(s_mwa),
    .mem_write_data(s_mwd), .mem_write_ready(1'b0));

  int total = 0, bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory models ----------------
  logic [7:0] mem [256];
  int lat = 2;
  int rcnt [4] = '{default: 0};
  int wcnt [4] = '{default: 0};
  int s_rcnt = 0;
  bit s_wr_seen = 1'b0;

  // Respond to a held request after 'lat' extra negedges; pulse ready one cycle.
  always @(negedge clk) begin
    for (int ch = 0; ch < 4; ch++) begin
      mrr[ch] = 1'b0;
      mwr[ch] = 1'b0;
      if (mrv[ch]) begin
        if (rcnt[ch] >= lat) begin
          mrr[ch] = 1'b1; mrd[ch] = mem[mra[ch]]; rcnt[ch] = 0;
        end else rcnt[ch]++;
      end else rcnt[ch] = 0;
      if (mwv[ch]) begin
        if (wcnt[ch] >= lat) begin
          mwr[ch] = 1'b1; mem[mwa[ch]] = mwd[ch]; wcnt[ch] = 0;
        end else wcnt[ch]++;
      end else wcnt[ch] = 0;
    end
    s_mrr[0] = 1'b0;
    if (s_mrv[0]) begin
      if (s_rcnt >= lat) begin
        s_mrr[0] = 1'b1; s_mrd[0] = mem[s_mra[0]]; s_rcnt = 0;
      end else s_rcnt++;
    end else s_rcnt = 0;
    if (s_mwv[0]) s_wr_seen = 1'b1;
  end

  // ---------------- scoreboards / monitors ----------------
  typedef struct { int c; bit wr; logic [7:0] d; } exp_t;
  exp_t sb [$];
  exp_t sb_s [$];
  logic [7:0] prr = '0, pwr = '0;
  logic [1:0] s_prr = '0;

  task automatic match(int c, bit wr, logic [7:0] d);
    int k = -1;
    for (int i = 0; i < sb.size(); i++) if (k < 0 && sb[i].c == c) k = i;
    if (k < 0) begin
      total++; bad++;
      $display("FAIL sb_unexpected: consumer %0d wr=%0d got %0h expected none", c, wr, d);
    end else begin
      check($sformatf("sb_c%0d", c), {55'd0, wr, d}, {55'd0, sb[k].wr, sb[k].d});
      sb.delete(k);
    end
  endtask

  // Compare each new response (rising ready) against the oldest expectation for that consumer.
  always @(negedge clk) begin
    for (int c = 0; c < 8; c++) begin
      if (crr[c] && !prr[c]) match(c, 1'b0, crd[c]);
      if (cwr[c] && !pwr[c]) match(c, 1'b1, 8'h00);
    end
    prr = crr;
    pwr = cwr;
    for (int c = 0; c < 2; c++)
      if (s_crr[c] && !s_prr[c]) begin
        if (sb_s.size() == 0) begin
          total++; bad++;
          $display("FAIL sbs_unexpected: fetcher %0d got %0h expected none", c, s_crd[c]);
        end else begin
          check("sbs_order", c, sb_s[0].c);
          check("sbs_data", s_crd[c], sb_s[0].d);
          void'(sb_s.pop_front());
        end
      end
    s_prr = s_crr;
  end

  // ---------------- stimulus helpers ----------------
  task automatic rd(int c, logic [7:0] a, logic [7:0] e);
    crv[c] = 1'b1; cra[c] = a;
    sb.push_back('{c, 1'b0, e});
  endtask

  task automatic wr(int c, logic [7:0] a, logic [7:0] d);
    cwv[c] = 1'b1; cwa[c] = a; cwd[c] = d;
    sb.push_back('{c, 1'b1, 8'h00});
  endtask

  // Consumers drop valid as soon as they see ready; bounded drain.
  task automatic drain(int budget);
    int n = 0;
    while ((crv != 0 || cwv != 0) && n < budget) begin
      @(negedge clk); n++;
      for (int c = 0; c < 8; c++) begin
        if (crr[c]) crv[c] = 1'b0;
        if (cwr[c]) cwv[c] = 1'b0;
      end
    end
    check("drain_timeout", {crv, cwv}, 16'h0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    crv = '0; cra = '0; cwv = '0; cwa = '0; cwd = '0;
    s_crv = '0; s_cra = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hFF;
    mem[8'h10] = 8'h5A;
    mem[8'h40] = 8'h4C;
    mem[8'h60] = 8'h91;
    mem[8'h61] = 8'h92;
    for (int i = 0; i < 8; i++) mem[8'(8'h20 + i)] = 8'(8'hC0 + i);

    repeat (3) @(negedge clk);
    check("rst_valids", {crr, cwr, mrv, mwv}, 24'h0);
    check("rst_rdata", crd, 64'h0);
    check("rst_maddr", {mra, mwa}, 64'h0);
    reset = 1'b1;
    @(negedge clk);

    // Single read: consumer 2, addr 0x10 -> 0x5A
    rd(2, 8'h10, 8'h5A);
    @(negedge clk);
    check("rd_req_valid", mrv, 4'h1);
    check("rd_req_addr", mra[0], 8'h10);
    n = 1;
    while (!crr[2] && n < 20) begin @(negedge clk); n++; end
    check("rd_resp_latency", n, 4);
    check("rd_mem_valid_low", mrv, 4'h0);
    check("rd_data", crd[2], 8'h5A);
    @(negedge clk);
    check("rd_hold_ready", crr[2], 1'b1);
    check("rd_hold_data", crd[2], 8'h5A);
    crv[2] = 1'b0;
    @(negedge clk);
    check("rd_release", crr, 8'h0);

    // Single write: consumer 0 writes 0x33 to 0x80
    wr(0, 8'h80, 8'h33);
    @(negedge clk);
    check("wr_req_valid", mwv, 4'h1);
    check("wr_req_addr", mwa[0], 8'h80);
    check("wr_req_data", mwd[0], 8'h33);
    check("wr_no_read", mrv, 4'h0);
    n = 1;
    while (!cwr[0] && n < 20) begin @(negedge clk); n++; end
    check("wr_ack_latency", n, 4);
    drain(20);
    check("wr_mem_content", mem[8'h80], 8'h33);

    // Read-back of the written location
    rd(5, 8'h80, 8'h33);
    drain(20);

    // Priority: consumer 1 read + write together -> read first
    rd(1, 8'h40, 8'h4C);
    wr(1, 8'h41, 8'h77);
    @(negedge clk);
    check("prio_read_first", mrv, 4'h1);
    check("prio_read_addr", mra[0], 8'h40);
    check("prio_no_write", mwv, 4'h0);
    drain(40);
    check("prio_write_done", mem[8'h41], 8'h77);

    // Contention: all 8 read at once; channels 0..3 take consumers 0..3
    for (int i = 0; i < 8; i++) rd(i, 8'(8'h20 + i), 8'(8'hC0 + i));
    @(negedge clk);
    check("cont_all_channels", mrv, 4'hF);
    check("cont_claims", mra, 32'h23222120);
    drain(200);

    // Reset during READ_WAITING
    lat = 5;
    crv[3] = 1'b1; cra[3] = 8'h50;
    @(negedge clk);
    check("mrst_waiting", mrv, 4'h1);
    reset = 1'b0;
    crv[3] = 1'b0;
    @(negedge clk);
    check("mrst_valids", {crr, cwr, mrv, mwv}, 24'h0);
    check("mrst_maddr", {mra, mwa}, 64'h0);
    check("mrst_mwdata", mwd, 32'h0);
    check("mrst_rdata", crd, 64'h0);
    reset = 1'b1;
    lat = 2;
    @(negedge clk);
    rd(3, 8'h10, 8'h5A);
    @(negedge clk);
    check("post_rst_claim", mrv, 4'h1);
    drain(40);
    check("sb_empty", sb.size(), 0);

    // Read-only instance: both fetchers at once, served 0 then 1
    s_crv = 2'b11; s_cra[0] = 8'h60; s_cra[1] = 8'h61;
    sb_s.push_back('{0, 1'b0, 8'h91});
    sb_s.push_back('{1, 1'b0, 8'h92});
    @(negedge clk);
    check("s_first_addr", s_mra[0], 8'h60);
    n = 0;
    while (s_crv != 0 && n < 60) begin
      @(negedge clk); n++;
      for (int c = 0; c < 2; c++) if (s_crr[c]) s_crv[c] = 1'b0;
    end
    check("s_drain_timeout", s_crv, 2'b00);
    @(negedge clk);
    check("s_sb_empty", sb_s.size(), 0);
    check("s_no_write", s_wr_seen, 1'b0);
    check("s_no_wack", s_cwr, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
